// File: rtl/layer_compositor.sv
// Priority compositor for N sprite/score layers over a background, with a dashed
// centre separator, frame-start detection, per-frame enable shadowing and overlap flags.
module layer_compositor #(
  parameter int N_LAYERS        = 4,
  parameter int COLOR_W         = 8,
  parameter int X_POS_W         = 11,
  parameter int Y_POS_W         = 10,
  parameter int SCREEN_H_RES    = 640,
  parameter int SEP_WIDTH       = 4,
  parameter int SEP_PERIOD_LOG2 = 5,
  parameter int SEP_DOT_H       = 16,
  parameter int SEP_PHASE       = 9,
  parameter int FCNT_W          = 16,
  localparam int RGB_W          = 3*COLOR_W
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [X_POS_W-1:0]              x_i,
  input  logic [Y_POS_W-1:0]              y_i,
  input  logic                            visible_i,
  input  logic                            vsync_i,
  input  logic [N_LAYERS-1:0]             layer_on_i,
  input  logic [N_LAYERS-1:0][RGB_W-1:0]  layer_rgb_i,
  input  logic [N_LAYERS-1:0]             layer_en_i,
  input  logic                            sep_en_i,
  input  logic [RGB_W-1:0]                bg_rgb_i,
  output logic [RGB_W-1:0]                rgb_o,
  output logic                            visible_o,
  output logic                            new_frame_o,
  output logic [FCNT_W-1:0]               frame_cnt_o,
  output logic [N_LAYERS-1:0]             overlap_o
);

  localparam logic [X_POS_W-1:0] SEP_LO = X_POS_W'(SCREEN_H_RES/2 - SEP_WIDTH/2);
  localparam logic [X_POS_W-1:0] SEP_HI = X_POS_W'(SCREEN_H_RES/2 + SEP_WIDTH/2);

  logic                           vsync_d;
  logic                           frame_start;
  logic [N_LAYERS-1:0]            layer_en_q;
  logic                           sep_en_q;
  logic [N_LAYERS-1:0]            hit_q;
  logic [N_LAYERS-1:0][RGB_W-1:0] rgb_q;
  logic [RGB_W-1:0]               bg_q;
  logic                           visible_q;
  logic                           sep_hit_q;
  logic [N_LAYERS-1:0]            acc;
  logic [Y_POS_W:0]               y_sum;
  logic                           sep_hit;
  logic                           multi_hit;
  logic [RGB_W-1:0]               layer_pix;
  logic [RGB_W-1:0]               pix_next;

  assign frame_start = vsync_d & ~vsync_i;

  // Dash phase uses one extra bit so the offset add never wraps before the modulo.
  assign y_sum   = {1'b0, y_i} + (Y_POS_W+1)'(SEP_PHASE);
  assign sep_hit = sep_en_q & (x_i > SEP_LO) & (x_i < SEP_HI) &
                   ({1'b0, y_sum[SEP_PERIOD_LOG2-1:0]} < (SEP_PERIOD_LOG2+1)'(SEP_DOT_H));

  // Clearing the lowest set bit leaves something only when two or more layers hit.
  assign multi_hit = (hit_q & (hit_q - N_LAYERS'(1))) != '0;

  always_comb begin
    layer_pix = bg_q;
    for (int i = 0; i < N_LAYERS; i++) begin
      if (hit_q[i]) layer_pix = rgb_q[i];
    end
    if (!visible_q)     pix_next = '0;
    else if (sep_hit_q) pix_next = '1;
    else                pix_next = layer_pix;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vsync_d     <= 1'b0;
      new_frame_o <= 1'b0;
      frame_cnt_o <= '0;
      overlap_o   <= '0;
      acc         <= '0;
      layer_en_q  <= '1;
      sep_en_q    <= 1'b1;
    end else begin
      vsync_d     <= vsync_i;
      new_frame_o <= frame_start;
      if (frame_start) begin
        layer_en_q  <= layer_en_i;
        sep_en_q    <= sep_en_i;
        frame_cnt_o <= frame_cnt_o + FCNT_W'(1);
        overlap_o   <= acc;
        acc         <= '0;
      end else if (visible_q && multi_hit) begin
        acc <= acc | hit_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_q     <= '0;
      rgb_q     <= '0;
      bg_q      <= '0;
      visible_q <= 1'b0;
      sep_hit_q <= 1'b0;
      rgb_o     <= '0;
      visible_o <= 1'b0;
    end else begin
      hit_q     <= layer_on_i & layer_en_q;
      rgb_q     <= layer_rgb_i;
      bg_q      <= bg_rgb_i;
      visible_q <= visible_i;
      sep_hit_q <= sep_hit;
      rgb_o     <= pix_next;
      visible_o <= visible_q;
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: directed scenarios plus randomized traffic checked
// against a pixel-level reference model of the compositing rules.
module tb_layer_compositor;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [10:0]      x = '0;
  logic [9:0]       y = '0;
  logic             visible = 1'b0;
  logic             vsync = 1'b0;
  logic [3:0]       layer_on = '0;
  logic [3:0][23:0] layer_rgb = '0;
  logic [3:0]       layer_en = 4'hF;
  logic             sep_en = 1'b1;
  logic [23:0]      bg = '0;
  logic [23:0]      rgb_o;
  logic             visible_o;
  logic             new_frame_o;
  logic [3:0]       frame_cnt_o;
  logic [3:0]       overlap_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic        m_vs_prev, m_sep, m_pend_vis, m_vis, m_nf;
  logic [3:0]  m_en, m_pend_hit, m_acc, m_ovl;
  logic [23:0] m_pend_rgb, m_rgb;
  int          m_cnt;

  layer_compositor #(.FCNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .x_i(x), .y_i(y), .visible_i(visible), .vsync_i(vsync),
    .layer_on_i(layer_on), .layer_rgb_i(layer_rgb), .layer_en_i(layer_en),
    .sep_en_i(sep_en), .bg_rgb_i(bg), .rgb_o(rgb_o), .visible_o(visible_o),
    .new_frame_o(new_frame_o), .frame_cnt_o(frame_cnt_o), .overlap_o(overlap_o)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] ref_pixel(input logic vis, input logic sep_on,
      input logic [3:0] hits, input logic [3:0][23:0] cols, input logic [23:0] bgc,
      input int xx, input int yy);
    if (!vis) return 24'h0;
    if (sep_on && xx >= 319 && xx <= 321 && ((yy + 9) % 32) < 16) return 24'hFFFFFF;
    for (int i = 3; i >= 0; i--) if (hits[i]) return cols[i];
    return bgc;
  endfunction

  task automatic model_reset();
    m_vs_prev = 0; m_sep = 1; m_en = 4'hF; m_pend_vis = 0; m_vis = 0; m_nf = 0;
    m_pend_hit = 0; m_acc = 0; m_ovl = 0; m_pend_rgb = 0; m_rgb = 0; m_cnt = 0;
  endtask

  // Advance one pixel clock; the model sees the same inputs the DUT sampled.
  task automatic cycle();
    logic fall;
    @(posedge clk);
    fall = m_vs_prev && !vsync;
    m_rgb = m_pend_rgb;
    m_vis = m_pend_vis;
    if (fall) begin
      m_ovl = m_acc; m_acc = 0; m_cnt = (m_cnt + 1) % 16;
    end else if (m_pend_vis && $countones(m_pend_hit) >= 2) begin
      m_acc = m_acc | m_pend_hit;
    end
    m_nf = fall;
    m_pend_hit = layer_on & m_en;
    m_pend_vis = visible;
    m_pend_rgb = ref_pixel(visible, m_sep, layer_on & m_en, layer_rgb, bg, int'(x), int'(y));
    if (fall) begin
      m_en = layer_en; m_sep = sep_en;
    end
    m_vs_prev = vsync;
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic frame_edge();
    vsync = 1'b1; cycle();
    vsync = 1'b0; cycle();
    cycle();
  endtask

  task automatic test_reset();
    vsync = 0; visible = 0; layer_on = 0; layer_en = 4'hF; sep_en = 1;
    apply_reset();
    vectors++; if (rgb_o !== 24'h0) begin miscompares++; $display("[TB] FAIL reset_rgb got=%h want=0", rgb_o); end
    vectors++; if (visible_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_visible got=%b want=0", visible_o); end
    vectors++; if (new_frame_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_new_frame got=%b want=0", new_frame_o); end
    vectors++; if (frame_cnt_o !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_frame_cnt got=%0d want=0", frame_cnt_o); end
    vectors++; if (overlap_o !== 4'b0) begin miscompares++; $display("[TB] FAIL reset_overlap got=%b want=0", overlap_o); end
  endtask

  task automatic test_priority();
    x = 100; y = 100; visible = 1; bg = 24'h000010;
    layer_rgb[1] = 24'h00FF00; layer_rgb[3] = 24'hFF0000; layer_on = 4'b1010;
    cycles(2);
    vectors++; if (rgb_o !== 24'hFF0000) begin miscompares++; $display("[TB] FAIL priority_top got=%h want=FF0000", rgb_o); end
    vectors++; if (visible_o !== 1'b1) begin miscompares++; $display("[TB] FAIL priority_visible got=%b want=1", visible_o); end
    layer_rgb[3] = 24'h00FF00; layer_rgb[1] = 24'h00FF00; layer_rgb[2] = 24'h0000AA; layer_on = 4'b0110;
    cycles(2);
    vectors++; if (rgb_o !== 24'h0000AA) begin miscompares++; $display("[TB] FAIL priority_mid got=%h want=0000AA", rgb_o); end
    layer_rgb[3] = 24'hFF0000; layer_on = 4'b0000;
    cycles(2);
    vectors++; if (rgb_o !== 24'h000010) begin miscompares++; $display("[TB] FAIL priority_bg got=%h want=000010", rgb_o); end
    layer_on = 4'b1010; visible = 0;
    cycles(2);
    vectors++; if (rgb_o !== 24'h0) begin miscompares++; $display("[TB] FAIL priority_blank got=%h want=0", rgb_o); end
    vectors++; if (visible_o !== 1'b0) begin miscompares++; $display("[TB] FAIL priority_blank_vis got=%b want=0", visible_o); end
  endtask

  task automatic test_separator();
    visible = 1; layer_on = 4'b1000; layer_rgb[3] = 24'hFF0000;
    x = 319; y = 0; cycles(2);
    vectors++; if (rgb_o !== 24'hFFFFFF) begin miscompares++; $display("[TB] FAIL sep_on got=%h want=FFFFFF", rgb_o); end
    y = 10; cycles(2);
    vectors++; if (rgb_o !== 24'hFF0000) begin miscompares++; $display("[TB] FAIL sep_gap got=%h want=FF0000", rgb_o); end
    x = 318; y = 0; cycles(2);
    vectors++; if (rgb_o !== 24'hFF0000) begin miscompares++; $display("[TB] FAIL sep_left got=%h want=FF0000", rgb_o); end
    x = 321; y = 6; cycles(2);
    vectors++; if (rgb_o !== 24'hFFFFFF) begin miscompares++; $display("[TB] FAIL sep_right_edge got=%h want=FFFFFF", rgb_o); end
    x = 322; cycles(2);
    vectors++; if (rgb_o !== 24'hFF0000) begin miscompares++; $display("[TB] FAIL sep_right got=%h want=FF0000", rgb_o); end
    x = 320; y = 7; cycles(2);
    vectors++; if (rgb_o !== 24'hFF0000) begin miscompares++; $display("[TB] FAIL sep_dash_end got=%h want=FF0000", rgb_o); end
  endtask

  task automatic test_frame_pulse();
    logic [4:0] seq;
    logic [4:0] seen;
    int pulses;
    apply_reset();
    visible = 0; layer_on = 0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (new_frame_o === 1'b1) pulses++;
    end
    vectors++; if (pulses !== 0) begin miscompares++; $display("[TB] FAIL held_low_pulses got=%0d want=0", pulses); end
    seq = 5'b00110;
    seen = '0;
    for (int i = 0; i < 5; i++) begin
      vsync = seq[i];
      cycle();
      seen[i] = new_frame_o;
    end
    vsync = 0;
    vectors++; if (seen !== 5'b01000) begin miscompares++; $display("[TB] FAIL pulse_shape got=%b want=01000", seen); end
    vectors++; if (frame_cnt_o !== 4'd1) begin miscompares++; $display("[TB] FAIL frame_cnt_one got=%0d want=1", frame_cnt_o); end
  endtask

  task automatic test_frame_wrap();
    apply_reset();
    for (int f = 0; f < 16; f++) frame_edge();
    vectors++; if (frame_cnt_o !== 4'd0) begin miscompares++; $display("[TB] FAIL wrap_16 got=%0d want=0", frame_cnt_o); end
    frame_edge();
    vectors++; if (frame_cnt_o !== 4'd1) begin miscompares++; $display("[TB] FAIL wrap_17 got=%0d want=1", frame_cnt_o); end
  endtask

  task automatic test_shadowing();
    apply_reset();
    x = 100; y = 50; visible = 1; bg = 24'h000001;
    layer_on = 4'b0100; layer_rgb[2] = 24'h123456; layer_en = 4'hF;
    cycles(3);
    layer_en = 4'b1011;
    cycles(4);
    vectors++; if (rgb_o !== 24'h123456) begin miscompares++; $display("[TB] FAIL shadow_hold got=%h want=123456", rgb_o); end
    vsync = 1; cycle();
    vsync = 0; cycle();
    cycle();
    vectors++; if (rgb_o !== 24'h123456) begin miscompares++; $display("[TB] FAIL shadow_edge_pixel got=%h want=123456", rgb_o); end
    cycle();
    vectors++; if (rgb_o !== 24'h000001) begin miscompares++; $display("[TB] FAIL shadow_suppressed got=%h want=000001", rgb_o); end
    layer_en = 4'hF;
    frame_edge();
  endtask

  task automatic test_overlap();
    apply_reset();
    layer_en = 4'hF; visible = 0; layer_on = 0; x = 50; y = 50;
    frame_edge();
    vectors++; if (overlap_o !== 4'b0000) begin miscompares++; $display("[TB] FAIL overlap_initial got=%b want=0000", overlap_o); end
    visible = 1; layer_on = 4'b0101; cycle();
    layer_on = 4'b0010; cycles(3);
    visible = 0; layer_on = 0; cycles(2);
    frame_edge();
    vectors++; if (overlap_o !== 4'b0101) begin miscompares++; $display("[TB] FAIL overlap_frame got=%b want=0101", overlap_o); end
    visible = 1; layer_on = 4'b1000; cycles(3);
    visible = 0; layer_on = 0; cycles(2);
    frame_edge();
    vectors++; if (overlap_o !== 4'b0000) begin miscompares++; $display("[TB] FAIL overlap_cleared got=%b want=0000", overlap_o); end
  endtask

  task automatic test_async_reset();
    layer_en = 4'b0000; visible = 0; layer_on = 0;
    frame_edge();
    visible = 1; x = 10; y = 10; layer_on = 4'b1001; layer_rgb[3] = 24'hABCDEF; layer_rgb[0] = 24'h010101;
    cycles(3);
    #2 rst = 1'b1;
    #1;
    vectors++; if (rgb_o !== 24'h0) begin miscompares++; $display("[TB] FAIL async_rgb got=%h want=0", rgb_o); end
    vectors++; if (frame_cnt_o !== 4'd0) begin miscompares++; $display("[TB] FAIL async_cnt got=%0d want=0", frame_cnt_o); end
    vectors++; if (visible_o !== 1'b0) begin miscompares++; $display("[TB] FAIL async_visible got=%b want=0", visible_o); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycles(2);
    vectors++; if (rgb_o !== 24'hABCDEF) begin miscompares++; $display("[TB] FAIL async_enables got=%h want=ABCDEF", rgb_o); end
    layer_en = 4'hF;
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 800; n++) begin
      x = 11'($urandom_range(310, 330));
      y = 10'($urandom_range(0, 479));
      visible = ($urandom_range(0, 7) != 0);
      layer_on = 4'($urandom);
      for (int i = 0; i < 4; i++) layer_rgb[i] = 24'($urandom);
      bg = 24'($urandom);
      if ($urandom_range(0, 9) == 0) vsync = ~vsync;
      if ($urandom_range(0, 39) == 0) layer_en = 4'($urandom);
      if ($urandom_range(0, 39) == 0) sep_en = 1'($urandom);
      cycle();
      vectors++; if (rgb_o !== m_rgb) begin miscompares++; $display("[TB] FAIL rand_rgb n=%0d got=%h want=%h", n, rgb_o, m_rgb); end
      vectors++; if (visible_o !== m_vis) begin miscompares++; $display("[TB] FAIL rand_visible n=%0d got=%b want=%b", n, visible_o, m_vis); end
      vectors++; if (new_frame_o !== m_nf) begin miscompares++; $display("[TB] FAIL rand_new_frame n=%0d got=%b want=%b", n, new_frame_o, m_nf); end
      vectors++; if (frame_cnt_o !== 4'(m_cnt)) begin miscompares++; $display("[TB] FAIL rand_frame_cnt n=%0d got=%0d want=%0d", n, frame_cnt_o, m_cnt); end
      vectors++; if (overlap_o !== m_ovl) begin miscompares++; $display("[TB] FAIL rand_overlap n=%0d got=%b want=%b", n, overlap_o, m_ovl); end
    end
    vsync = 0; sep_en = 1; layer_en = 4'hF;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_priority();
    test_separator();
    test_frame_pulse();
    test_frame_wrap();
    test_shadowing();
    test_overlap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
